// File: rtl/pattern_sequencer.sv
// pattern_sequencer: frame scheduler feeding a NeoPixel encoder.
// Walks the color/pixel arrays one entry per load, issues N loads per
// frame, fires go, waits for the encoder to finish, then holds the frame
// for HOLD_CYCLES before continuing from where it stopped.
module pattern_sequencer #(
  parameter int HOLD_CYCLES = 1_500_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [62:0][7:0] color_array,
  input  logic [62:0][2:0] pixel_array,
  input  logic [6:0]       max_num_loads,
  input  logic             ready,
  output logic             load,
  output logic [2:0]       pixel_index,
  output logic [1:0]       color_index,
  output logic [7:0]       color_level,
  output logic             go,
  output logic             frame_done,
  output logic [5:0]       entry_ptr
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_GO        = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_HOLD      = 3'd5;

  // Number of go cycles the encoder may ignore before go is reissued.
  localparam logic [3:0] BUSY_LAST = 4'd15;

  logic [2:0]        state_q, state_d;
  logic [5:0]        entry_ptr_q, entry_ptr_d;
  logic [1:0]        chan_q, chan_d;
  logic [5:0]        load_cnt_q, load_cnt_d;
  logic [5:0]        num_loads_q, num_loads_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        busy_cnt_q, busy_cnt_d;

  // Map the requested frame length into 1..63: zero still sends one entry,
  // anything beyond the array length is limited to one full pass.
  function automatic logic [5:0] clamp_loads(input logic [6:0] req);
    if (req == 7'd0) begin
      return 6'd1;
    end else if (req > 7'd63) begin
      return 6'd63;
    end else begin
      return req[5:0];
    end
  endfunction

  // Next-state, counter updates and the ready-qualified strobes.
  always_comb begin
    state_d     = state_q;
    entry_ptr_d = entry_ptr_q;
    chan_d      = chan_q;
    load_cnt_d  = load_cnt_q;
    num_loads_d = num_loads_q;
    hold_cnt_d  = hold_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    load        = 1'b0;
    go          = 1'b0;
    frame_done  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_LOAD;
          num_loads_d = clamp_loads(max_num_loads);
          load_cnt_d  = 6'd0;
        end
      end

      ST_LOAD: begin
        load = ready;
        if (ready) begin
          entry_ptr_d = (entry_ptr_q == 6'd62) ? 6'd0 : entry_ptr_q + 6'd1;
          chan_d      = (chan_q == 2'd2) ? 2'd0 : chan_q + 2'd1;
          load_cnt_d  = load_cnt_q + 6'd1;
          if (load_cnt_q == num_loads_q - 6'd1) begin
            state_d = ST_GO;
          end
        end
      end

      ST_GO: begin
        go = ready;
        if (ready) begin
          state_d    = ST_WAIT_BUSY;
          busy_cnt_d = 4'd0;
        end
      end

      ST_WAIT_BUSY: begin
        // Encoder acknowledges by dropping ready; if it never does, the go
        // pulse was presumably missed, so send it again.
        if (!ready) begin
          state_d = ST_WAIT_DONE;
        end else if (busy_cnt_q == BUSY_LAST) begin
          state_d = ST_GO;
        end else begin
          busy_cnt_d = busy_cnt_q + 4'd1;
        end
      end

      ST_WAIT_DONE: begin
        if (ready) begin
          frame_done = 1'b1;
          hold_cnt_d = '0;
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (enable) begin
            state_d     = ST_LOAD;
            num_loads_d = clamp_loads(max_num_loads);
            load_cnt_d  = 6'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; entry pointer and channel survive frames.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      entry_ptr_q <= 6'd0;
      chan_q      <= 2'd0;
      load_cnt_q  <= 6'd0;
      num_loads_q <= 6'd1;
      hold_cnt_q  <= '0;
      busy_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      entry_ptr_q <= entry_ptr_d;
      chan_q      <= chan_d;
      load_cnt_q  <= load_cnt_d;
      num_loads_q <= num_loads_d;
      hold_cnt_q  <= hold_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign entry_ptr   = entry_ptr_q;
  assign color_index = chan_q;
  assign pixel_index = pixel_array[entry_ptr_q];
  assign color_level = color_array[entry_ptr_q];

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a short hold time.
module tb_pattern_sequencer;

  localparam int H = 4;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [62:0][7:0] color_array;
  logic [62:0][2:0] pixel_array;
  logic [6:0]       max_num_loads;
  logic             ready;
  logic             load;
  logic [2:0]       pixel_index;
  logic [1:0]       color_index;
  logic [7:0]       color_level;
  logic             go;
  logic             frame_done;
  logic [5:0]       entry_ptr;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  int mchan  = 0;

  pattern_sequencer #(.HOLD_CYCLES(H)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .color_array  (color_array),
    .pixel_array  (pixel_array),
    .max_num_loads(max_num_loads),
    .ready        (ready),
    .load         (load),
    .pixel_index  (pixel_index),
    .color_index  (color_index),
    .color_level  (color_level),
    .go           (go),
    .frame_done   (frame_done),
    .entry_ptr    (entry_ptr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_load, input logic e_go,
                          input logic e_fd);
    logic [31:0] e_pix;
    logic [31:0] e_col;
    e_pix = 32'(mptr % 8);
    e_col = 32'((mptr * 3 + 7) % 256);
    chk({tag, ".load"}, 32'(load), 32'(e_load));
    chk({tag, ".go"}, 32'(go), 32'(e_go));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
    chk({tag, ".entry_ptr"}, 32'(entry_ptr), 32'(mptr));
    chk({tag, ".color_index"}, 32'(color_index), 32'(mchan));
    chk({tag, ".pixel_index"}, 32'(pixel_index), e_pix);
    chk({tag, ".color_level"}, 32'(color_level), e_col);
  endtask

  task automatic advance();
    mptr  = (mptr == 62) ? 0 : mptr + 1;
    mchan = (mchan == 2) ? 0 : mchan + 1;
  endtask

  // Runs one frame starting at a negedge with the DUT in LOAD.
  // n: expected loads; next_max/next_en: inputs for the following frame
  // (max also changed at load index 2 to exercise a mid-frame change);
  // stall_at: load index before which ready drops for 3 cycles;
  // reissues: number of ignored go pulses; busy_len: cycles ready stays low;
  // rst_in_hold: pulse reset in the second hold cycle and return in IDLE.
  task automatic frame(input int n, input logic [6:0] next_max, input logic next_en,
                       input int stall_at, input int reissues, input int busy_len,
                       input logic rst_in_hold);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          ready = 1'b0;
          #1 chk_outs("stall", 1'b0, 1'b0, 1'b0);
          cyc();
        end
      end
      ready = 1'b1;
      if (i == 2) max_num_loads = next_max;
      #1 chk_outs("load", 1'b1, 1'b0, 1'b0);
      advance();
      cyc();
    end
    max_num_loads = next_max;
    enable        = next_en;
    #1 chk_outs("go", 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < reissues; r++) begin
      for (int k = 0; k < 16; k++) begin
        cyc();
        #1 chk_outs("busy_wait", 1'b0, 1'b0, 1'b0);
      end
      cyc();
      #1 chk_outs("go_reissue", 1'b0, 1'b1, 1'b0);
    end
    cyc();
    #1 chk_outs("wait_busy", 1'b0, 1'b0, 1'b0);
    cyc();
    ready = 1'b0;
    #1 chk_outs("ready_drop", 1'b0, 1'b0, 1'b0);
    for (int b = 1; b < busy_len; b++) begin
      cyc();
      #1 chk_outs("sending", 1'b0, 1'b0, 1'b0);
    end
    cyc();
    ready = 1'b1;
    #1 chk_outs("frame_done", 1'b0, 1'b0, 1'b1);
    for (int h = 0; h < H; h++) begin
      cyc();
      #1 chk_outs("hold", 1'b0, 1'b0, 1'b0);
      if (rst_in_hold && h == 1) begin
        reset = 1'b0;
        #1;
        mptr  = 0;
        mchan = 0;
        chk_outs("reset_hold", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1 chk_outs("reset_hold_exit", 1'b0, 1'b0, 1'b0);
        return;
      end
    end
    cyc();
  endtask

  initial begin
    reset         = 1'b0;
    enable        = 1'b0;
    ready         = 1'b1;
    max_num_loads = 7'd15;
    for (int i = 0; i < 63; i++) begin
      color_array[i] = 8'((i * 3 + 7) % 256);
      pixel_array[i] = 3'(i % 8);
    end

    // Reset state
    cyc();
    cyc();
    #1 chk_outs("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc();
    #1 chk_outs("idle_disabled", 1'b0, 1'b0, 1'b0);

    // First frame: 15 loads, encoder busy 50 cycles after go
    enable = 1'b1;
    cyc();
    frame(15, 7'd63, 1'b1, -1, 0, 50, 1'b0);
    // Two full-array frames, wrapping 62 -> 0
    frame(63, 7'd63, 1'b1, -1, 0, 3, 1'b0);
    frame(63, 7'd15, 1'b1, -1, 0, 3, 1'b0);
    // Stall mid-load
    frame(15, 7'd0, 1'b1, 5, 0, 3, 1'b0);
    // Zero maps to one load
    frame(1, 7'd100, 1'b1, -1, 0, 3, 1'b0);
    // Oversized request clamps to 63
    frame(63, 7'd15, 1'b1, -1, 0, 3, 1'b0);
    // Mid-frame change to 31 affects only the next frame
    frame(15, 7'd31, 1'b1, -1, 0, 3, 1'b0);
    // Encoder ignores go twice
    frame(31, 7'd4, 1'b1, -1, 2, 3, 1'b0);
    // Enable low at hold end parks in IDLE
    frame(4, 7'd4, 1'b0, -1, 0, 3, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      #1 chk_outs("parked", 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of LOAD
    enable = 1'b1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      #1 chk_outs("pre_reset_load", 1'b1, 1'b0, 1'b0);
      advance();
      cyc();
    end
    reset = 1'b0;
    #1;
    mptr  = 0;
    mchan = 0;
    chk_outs("reset_load", 1'b0, 1'b0, 1'b0);
    cyc();
    #1 chk_outs("reset_held", 1'b0, 1'b0, 1'b0);
    max_num_loads = 7'd6;
    reset = 1'b1;
    #1 chk_outs("reset_exit", 1'b0, 1'b0, 1'b0);
    cyc();
    // Reset during HOLD, then a last frame that parks
    frame(6, 7'd3, 1'b1, -1, 0, 3, 1'b1);
    cyc();
    frame(3, 7'd3, 1'b0, -1, 0, 3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1 chk_outs("final_idle", 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
